lsu_subword: RTL and testbench
==============================

# lsu_subword

Load/store unit between the core's memory-access stage and the word-organised data memory `RAM`.
- Accepts byte, halfword and word load/store requests through a valid/ready handshake.
- Drives the RAM's word port and performs read-modify-write for sub-word stores.
- Returns sign- or zero-extended load data with an error flag.

## Interface
Parameters:
- RAM_DEPTH, 1024: data memory depth in 32-bit words; RAM address width is $clog2(RAM_DEPTH).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, request accepted when req_valid & req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected; qualifies rsp_valid.
- ram_we  out  1  RAM write enable.
- ram_addr  out  $clog2(RAM_DEPTH)  word index, req_addr[$clog2(RAM_DEPTH)+1:2].
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, combinational from ram_addr.

## Operation
- Little-endian lanes: byte k = bits 8k+7:8k. Half at addr[1]=1 uses bits 31:16.
- Address bits above the RAM index are ignored, so accesses wrap modulo RAM_DEPTH words.
- FSM states:
  - IDLE: req_ready=1. On accept, latch all request fields.
    - Error request → RESP.
    - Load → LOAD.
    - Word store → WRITE.
    - Byte/half store → RMW_READ.
  - LOAD: ram_addr driven. The addressed lane of ram_rdata is extracted, extended and registered into rsp_rdata → RESP.
  - RMW_READ: ram_rdata captured into the merge register. The addressed lane is replaced with req_wdata[7:0] or [15:0] → WRITE.
  - WRITE: ram_we=1, ram_wdata = merged word (sub-word) or req_wdata (word) → RESP.
  - RESP: rsp_valid=1 for exactly one cycle → IDLE.
- req_ready=0 in every state except IDLE. A request held during busy waits and is not lost.
- Error conditions:
  - req_size=11: always an error.
  - Misalignment: see Configuration.
- On error: rsp_err=1, rsp_rdata=0, ram_we never asserted.
- ram_we is 0 in all states except WRITE. ram_wdata is don't-care when ram_we=0.

## Timing
- Cycle 0 is the cycle req_valid & req_ready is sampled high.
- rsp_valid high in:
  - load: cycle 2
  - word store: cycle 2 (RAM written at end of cycle 1)
  - sub-word store: cycle 3 (RAM written at end of cycle 2)
  - error: cycle 1
- Next request can be accepted in the cycle after RESP.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_we=0, merge register 0.
- Reset mid-operation: the request is aborted and no response is issued. ram_we drops immediately. A RAM write occurs only if the WRITE-state edge precedes reset assertion.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, is an error with 1-cycle latency.
- LSU_MISALIGN_TRAP_EN undefined:
  - Offending low address bits are forced to 0 (half clears addr[0], word clears addr[1:0]) and the access proceeds normally.
  - rsp_err is asserted only for req_size=11.

## Structure
- Package lsu_pkg:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD)
  - FSM state enum
  - function computing the misalignment predicate
- Sub-module lsu_lane (combinational):
  - extract/extend for loads: word, offset, size, unsigned → 32-bit result
  - merge for stores: old word, new data, offset, size → merged word
- The FSM stays in lsu_subword.

## Test plan
1. Word store 0x12345678 to 0x10, then word load 0x10 → RAM[4]=0x12345678; rsp_rdata=0x12345678 in cycle 2; rsp_err=0.
2. Byte store 0x000000AB to 0x13 → ram_we only in cycle 2; RAM[4]=0xAB345678. Signed byte load 0x13 → 0xFFFFFFAB; unsigned → 0x000000AB.
3. Half store 0x000000CD to 0x10 → RAM[4]=0xAB3400CD. Signed half load 0x12 → 0xFFFFAB34; unsigned half load 0x10 → 0x000000CD.
4. Word load 0x11:
   - macro defined → rsp_valid in cycle 1, rsp_err=1, rsp_rdata=0.
   - macro undefined → 0xAB3400CD, rsp_err=0.
   - req_size=11 store → error, ram_we never high.
5. req_valid held high over two back-to-back requests → req_ready low from cycle 1 until after RESP; second request accepted in cycle 3 (load) or cycle 4 (sub-word store); both responses correct.
6. reset asserted during RMW_READ of byte store 0xEE to 0x10 → ram_we stays 0, no rsp_valid, RAM[4] unchanged, req_ready=1 immediately.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the sub-word load/store unit.
// The misalignment helpers are used by lsu_subword; the behaviour they select
// depends on LSU_MISALIGN_TRAP_EN (see lsu_subword.sv).
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RMW_READ = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

  // True when the low address bits are not a multiple of the access size.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
    case (size)
      SZ_HALF: return off[0];
      SZ_WORD: return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Clears the offending low offset bits so the access lands on its natural boundary.
  function automatic logic [1:0] align_offset(input size_e size, input logic [1:0] off);
    case (size)
      SZ_HALF: return {off[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: extracts and extends the addressed lane of a RAM
// word for loads, and merges new store data into an old word for sub-word stores.
// Little-endian: byte k occupies bits 8k+7:8k; half at offset 2 uses bits 31:16.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  size_e       sz;
  logic [31:0] shifted;

  assign sz      = size_e'(size_i);
  assign shifted = word_i >> {off_i, 3'b000};

  // Load path: shift the addressed lane down, then sign- or zero-extend.
  always_comb begin
    load_o = word_i;
    case (sz)
      SZ_BYTE: load_o = unsigned_i ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_o = unsigned_i ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: load_o = word_i;
    endcase
  end

  // Store path: replace only the addressed lane of the old word.
  always_comb begin
    merge_o = word_i;
    case (sz)
      SZ_BYTE: merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: begin
        if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
        else          merge_o[15:0]  = wdata_i[15:0];
      end
      SZ_WORD: merge_o = wdata_i;
      default: merge_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_subword.sv
// Load/store unit between the memory-access stage and a word-organised RAM.
// Byte/half stores are done as read-modify-write over the single RAM word port.
// Optional macro LSU_MISALIGN_TRAP_EN: when defined, misaligned half/word
// accesses are rejected with rsp_err; when undefined, the offending low
// address bits are cleared and the access proceeds.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | ready for a request; latches all fields on accept
// ST_LOAD     | RAM word read, addressed lane extended into rsp_rdata
// ST_RMW_READ | RAM word read and merged with the store data
// ST_WRITE    | ram_we high, merged word (or full store word) written
// ST_RESP     | one-cycle response pulse
module lsu_subword
  import lsu_pkg::*;
#(
  parameter int RAM_DEPTH = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [1:0]                   req_size,
  input  logic                         req_unsigned,
  input  logic [31:0]                  req_addr,
  input  logic [31:0]                  req_wdata,
  output logic                         rsp_valid,
  output logic [31:0]                  rsp_rdata,
  output logic                         rsp_err,
  output logic                         ram_we,
  output logic [$clog2(RAM_DEPTH)-1:0] ram_addr,
  output logic [31:0]                  ram_wdata,
  input  logic [31:0]                  ram_rdata
);

  localparam int AW = $clog2(RAM_DEPTH);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  size_e         size_q, size_d;
  logic          uns_q, uns_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   merge_q, merge_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  size_e         req_sz;
  logic          req_err;
  logic [1:0]    req_off;
  logic [31:0]   lane_load;
  logic [31:0]   lane_merge;

  // Address bits above the RAM index are deliberately ignored (accesses wrap).
  logic          unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign req_sz = size_e'(req_size);

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = (req_sz == SZ_RSVD) | is_misaligned(req_sz, req_addr[1:0]);
  assign req_off = req_addr[1:0];
`else
  assign req_err = (req_sz == SZ_RSVD);
  assign req_off = align_offset(req_sz, req_addr[1:0]);
`endif

  lsu_lane u_lane (
    .word_i     (ram_rdata),
    .wdata_i    (wdata_q),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .load_o     (lane_load),
    .merge_o    (lane_merge)
  );

  // Next-state and datapath register updates for the access sequence.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    idx_d   = idx_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_sz;
          uns_d   = req_unsigned;
          idx_d   = req_addr[AW+1:2];
          off_d   = req_off;
          wdata_d = req_wdata;
          rdata_d = 32'h0;
          err_d   = req_err;
          if (req_err)              state_d = ST_RESP;
          else if (!req_we)         state_d = ST_LOAD;
          else if (req_sz == SZ_WORD) state_d = ST_WRITE;
          else                      state_d = ST_RMW_READ;
        end
      end
      ST_LOAD: begin
        rdata_d = lane_load;
        state_d = ST_RESP;
      end
      ST_RMW_READ: begin
        merge_d = lane_merge;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and request registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      idx_q   <= '0;
      off_q   <= 2'b00;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = (state_q == ST_RESP) & err_q;
  assign ram_we    = (state_q == ST_WRITE) & we_q;
  assign ram_addr  = (state_q == ST_IDLE) ? req_addr[AW+1:2] : idx_q;
  assign ram_wdata = (size_q == SZ_WORD) ? wdata_q : merge_q;

endmodule

// File: tb/tb_lsu_subword.sv
// Directed testbench for lsu_subword with a behavioural word RAM.
module tb_lsu_subword;

  localparam int RAM_DEPTH = 1024;
  localparam int AW = $clog2(RAM_DEPTH);
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [31:0]   req_addr = 32'h0, req_wdata = 32'h0;
  logic          rsp_valid, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  logic [31:0]   mem [RAM_DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  lsu_subword #(.RAM_DEPTH(RAM_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_ram4;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input logic [31:0] exp_ram4);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_ram4 = exp_ram4;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
  endtask

  // Single request from IDLE; measures latency, write cycle and response fields.
  task automatic run_vec(input vec_t v, input int idx);
    int          lat, we_cnt, we_cyc, exp_we;
    logic [31:0] rd;
    logic        er;
    lat = 0; we_cnt = 0; we_cyc = 0; rd = 32'hx; er = 1'bx;
    drive(v);
    req_valid = 1'b1;
    chk($sformatf("v%0d_ready", idx), {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (ram_we) begin we_cnt++; we_cyc = k; end
      if (rsp_valid) begin lat = k; rd = rsp_rdata; er = rsp_err; break; end
      @(posedge clk); #1;
    end
    exp_we = (v.we && !v.exp_err) ? 1 : 0;
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
    chk($sformatf("v%0d_err", idx), {31'h0, er}, {31'h0, v.exp_err});
    chk($sformatf("v%0d_we_count", idx), we_cnt, exp_we);
    chk($sformatf("v%0d_we_cycle", idx), we_cyc, exp_we ? v.exp_lat - 1 : 0);
    @(posedge clk); #1;
    chk($sformatf("v%0d_pulse", idx), {31'h0, rsp_valid}, 32'h0);
    chk($sformatf("v%0d_idle_ready", idx), {31'h0, req_ready}, 32'h1);
    chk($sformatf("v%0d_ram4", idx), mem[4], v.exp_ram4);
  endtask

  // Two requests with req_valid held high across the first one.
  task automatic run_b2b(input string nm, input vec_t a, input vec_t b,
                         input int exp_acc, input int exp_r2, input logic [31:0] exp_ram4);
    int          acc, r1, r2, ready_bad;
    logic [31:0] d1, d2;
    logic        e1, e2;
    acc = 0; r1 = 0; r2 = 0; ready_bad = 0;
    d1 = 32'hx; d2 = 32'hx; e1 = 1'bx; e2 = 1'bx;
    drive(a);
    req_valid = 1'b1;
    @(posedge clk); #1;
    drive(b);
    for (int c = 1; c <= 12; c++) begin
      if (acc == 0 && c < exp_acc && req_ready) ready_bad++;
      if (rsp_valid) begin
        if (r1 == 0) begin r1 = c; d1 = rsp_rdata; e1 = rsp_err; end
        else if (r2 == 0) begin r2 = c; d2 = rsp_rdata; e2 = rsp_err; end
      end
      if (req_valid && req_ready && acc == 0) acc = c;
      @(posedge clk); #1;
      if (acc != 0) req_valid = 1'b0;
      if (r2 != 0) break;
    end
    req_valid = 1'b0;
    chk({nm, "_accept_cycle"}, acc, exp_acc);
    chk({nm, "_ready_busy"}, ready_bad, 0);
    chk({nm, "_rsp1_cycle"}, r1, a.exp_lat);
    chk({nm, "_rsp1_rdata"}, d1, a.exp_rdata);
    chk({nm, "_rsp1_err"}, {31'h0, e1}, {31'h0, a.exp_err});
    chk({nm, "_rsp2_cycle"}, r2, exp_r2);
    chk({nm, "_rsp2_rdata"}, d2, b.exp_rdata);
    chk({nm, "_rsp2_err"}, {31'h0, e2}, {31'h0, b.exp_err});
    chk({nm, "_ram4"}, mem[4], exp_ram4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    for (int i = 0; i < RAM_DEPTH; i++) mem[i] = 32'h0;

    vecs[0]  = mk(1, W, 0, 32'h10, 32'h12345678, 32'h0,        0, 2, 32'h12345678);
    vecs[1]  = mk(0, W, 0, 32'h10, 32'h0,        32'h12345678, 0, 2, 32'h12345678);
    vecs[2]  = mk(1, B, 0, 32'h13, 32'h000000AB, 32'h0,        0, 3, 32'hAB345678);
    vecs[3]  = mk(0, B, 0, 32'h13, 32'h0,        32'hFFFFFFAB, 0, 2, 32'hAB345678);
    vecs[4]  = mk(0, B, 1, 32'h13, 32'h0,        32'h000000AB, 0, 2, 32'hAB345678);
    vecs[5]  = mk(1, H, 0, 32'h10, 32'h000000CD, 32'h0,        0, 3, 32'hAB3400CD);
    vecs[6]  = mk(0, H, 0, 32'h12, 32'h0,        32'hFFFFAB34, 0, 2, 32'hAB3400CD);
    vecs[7]  = mk(0, H, 1, 32'h10, 32'h0,        32'h000000CD, 0, 2, 32'hAB3400CD);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[8]  = mk(0, W, 0, 32'h11, 32'h0,        32'h0,        1, 1, 32'hAB3400CD);
`else
    vecs[8]  = mk(0, W, 0, 32'h11, 32'h0,        32'hAB3400CD, 0, 2, 32'hAB3400CD);
`endif
    vecs[9]  = mk(1, R, 0, 32'h10, 32'hFFFFFFFF, 32'h0,        1, 1, 32'hAB3400CD);
    vecs[10] = mk(0, R, 1, 32'h10, 32'h0,        32'h0,        1, 1, 32'hAB3400CD);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[11] = mk(1, H, 0, 32'h11, 32'h00001234, 32'h0,        1, 1, 32'hAB3400CD);
    vecs[12] = mk(0, B, 1, 32'h12, 32'h0,        32'h00000034, 0, 2, 32'hAB3400CD);
`else
    vecs[11] = mk(1, H, 0, 32'h11, 32'h00001234, 32'h0,        0, 3, 32'hAB341234);
    vecs[12] = mk(0, B, 1, 32'h12, 32'h0,        32'h00000034, 0, 2, 32'hAB341234);
`endif
    vecs[13] = mk(1, W, 0, 32'h1010, 32'hCAFEF00D, 32'h0,      0, 2, 32'hCAFEF00D);
    vecs[14] = mk(0, H, 0, 32'h10, 32'h0,        32'hFFFFF00D, 0, 2, 32'hCAFEF00D);
    vecs[15] = mk(1, B, 0, 32'h11, 32'h00000155, 32'h0,        0, 3, 32'hCAFE550D);
    vecs[16] = mk(0, B, 0, 32'h11, 32'h0,        32'h00000055, 0, 2, 32'hCAFE550D);

    // Reset values
    #1 reset = 1'b1;
    #2;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

    // Load then sub-word store, req_valid held: second accepted in cycle 3.
    run_b2b("b2b_ld_st",
            mk(0, W, 0, 32'h10, 32'h0, 32'hCAFE550D, 0, 2, 32'h0),
            mk(1, B, 0, 32'h12, 32'h000000EE, 32'h0, 0, 3, 32'h0),
            3, 6, 32'hCAEE550D);
    // Sub-word store then load, req_valid held: second accepted in cycle 4.
    run_b2b("b2b_st_ld",
            mk(1, B, 0, 32'h13, 32'h00000011, 32'h0, 0, 3, 32'h0),
            mk(0, B, 1, 32'h13, 32'h0, 32'h00000011, 0, 2, 32'h0),
            4, 6, 32'h11EE550D);

    // Reset during RMW_READ of a byte store: aborted, no write, no response.
    drive(mk(1, B, 0, 32'h10, 32'h000000EE, 32'h0, 0, 3, 32'h0));
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rmw_rst_pre_we", {31'h0, ram_we}, 32'h0);
    chk("rmw_rst_pre_ready", {31'h0, req_ready}, 32'h0);
    reset = 1'b1;
    #1;
    chk("rmw_rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rmw_rst_we", {31'h0, ram_we}, 32'h0);
    chk("rmw_rst_rsp", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid || ram_we) bad++;
      @(posedge clk); #1;
    end
    chk("rmw_rst_quiet", bad, 0);
    chk("rmw_rst_ram4", mem[4], 32'h11EE550D);

    // Reset asserted in WRITE before its edge: ram_we drops, RAM untouched.
    drive(mk(1, B, 0, 32'h10, 32'h000000EE, 32'h0, 0, 3, 32'h0));
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("wr_rst_pre_we", {31'h0, ram_we}, 32'h1);
    reset = 1'b1;
    #1;
    chk("wr_rst_we", {31'h0, ram_we}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("wr_rst_ram4", mem[4], 32'h11EE550D);
    chk("wr_rst_rsp", {31'h0, rsp_valid}, 32'h0);

    // Unit works normally after the aborted accesses.
    run_vec(mk(0, W, 0, 32'h10, 32'h0, 32'h11EE550D, 0, 2, 32'h11EE550D), 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
